// File: rtl/victim_way_sel_d_cache_pkg.sv
// Shared types and constants for the d-cache victim-way selector.
// Covers the way-index width, the LFSR feedback taps and the offer FSM states.
package victim_way_sel_d_cache_pkg;

  // Galois feedback mask for x^16+x^14+x^13+x^11+1 in the right-shifting form
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } vsel_state_e;

  function automatic int way_w(input int ways);
    return $clog2(ways);
  endfunction

endpackage

// File: rtl/victim_way_sel_d_cache_lfsr16.sv
// Free-running 16-bit Galois LFSR used to pick a replacement way when every way is valid.
// The seed must be non-zero so the sequence never locks at zero.
module victim_lfsr16
  import victim_way_sel_d_cache_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_POLY;
    end else begin
      lfsr_d = lfsr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= lfsr_d;
    end else begin
      lfsr_q <= lfsr_q;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/victim_way_sel_d_cache.sv
// Per-way valid tracker with multi-port invalidate and a registered victim-way offer.
// Victim choice: lowest invalid way first, otherwise a pseudo-random way from the LFSR.
module victim_way_sel_d_cache
  import victim_way_sel_d_cache_pkg::*;
#(
  parameter int          WAYS      = 16,
  parameter int          NUM_INV   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         WAY_W     = way_w(WAYS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_INV-1:0]       inv_en,
  input  logic [NUM_INV*WAY_W-1:0] inv_way,
  input  logic                     fill_en,
  input  logic [WAY_W-1:0]         fill_way,
  input  logic                     victim_req,
  output logic                     victim_valid,
  input  logic                     victim_ready,
  output logic [WAY_W-1:0]         victim_way,
  output logic                     victim_invalid,
  output logic [WAYS-1:0]          valid_out,
  output logic [WAY_W:0]           valid_count
);

  vsel_state_e      state_q;
  logic             victim_valid_q;
  logic [WAY_W-1:0] victim_way_q;
  logic             victim_invalid_q;
  logic [WAYS-1:0]  valid_q;
  logic [WAYS-1:0]  valid_d;
  logic [WAY_W:0]   count_q;
  logic [WAY_W:0]   count_d;
  logic [WAY_W-1:0] first_inv_s;
  logic             have_inv_s;
  logic [15:0]      lfsr_s;

  victim_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .q     (lfsr_s)
  );

  // Invalidates are applied after the fill so they win on a shared way
  always_comb begin
    valid_d = valid_q;
    if (fill_en) begin
      valid_d[fill_way] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
    for (int p = 0; p < NUM_INV; p++) begin
      if (inv_en[p]) begin
        valid_d[inv_way[p*WAY_W +: WAY_W]] = 1'b0;
      end
    end
    count_d = '0;
    for (int i = 0; i < WAYS; i++) begin
      count_d = count_d + (WAY_W+1)'(valid_d[i]);
    end
  end

  // Scan downward so the lowest invalid index is the one left standing
  always_comb begin
    first_inv_s = '0;
    have_inv_s  = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        first_inv_s = WAY_W'(i);
        have_inv_s  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      victim_valid_q   <= 1'b0;
      victim_way_q     <= '0;
      victim_invalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (victim_req) begin
            state_q          <= OFFER;
            victim_valid_q   <= 1'b1;
            victim_way_q     <= have_inv_s ? first_inv_s : lfsr_s[WAY_W-1:0];
            victim_invalid_q <= have_inv_s;
          end
        end
        OFFER: begin
          if (victim_ready) begin
            state_q        <= IDLE;
            victim_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= IDLE;
          victim_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign victim_valid   = victim_valid_q;
  assign victim_way     = victim_way_q;
  assign victim_invalid = victim_invalid_q;
  assign valid_out      = valid_q;
  assign valid_count    = count_q;

endmodule

// File: tb/tb_victim_way_sel_d_cache.sv
// Randomised and directed bench for victim_way_sel_d_cache against a behavioural model.
module tb_victim_way_sel_d_cache;

  localparam int WAYS    = 16;
  localparam int NUM_INV = 2;
  localparam int WAY_W   = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_INV-1:0]       inv_en;
  logic [NUM_INV*WAY_W-1:0] inv_way;
  logic                     fill_en;
  logic [WAY_W-1:0]         fill_way;
  logic                     victim_req;
  logic                     victim_valid;
  logic                     victim_ready;
  logic [WAY_W-1:0]         victim_way;
  logic                     victim_invalid;
  logic [WAYS-1:0]          valid_out;
  logic [WAY_W:0]           valid_count;

  victim_way_sel_d_cache #(.WAYS(WAYS), .NUM_INV(NUM_INV), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .inv_en(inv_en), .inv_way(inv_way),
    .fill_en(fill_en), .fill_way(fill_way), .victim_req(victim_req),
    .victim_valid(victim_valid), .victim_ready(victim_ready), .victim_way(victim_way),
    .victim_invalid(victim_invalid), .valid_out(valid_out), .valid_count(valid_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit started = 1'b0;

  // Behavioural model state
  bit [15:0] m_valid;
  bit [15:0] m_lfsr;
  bit        m_offer;
  int        m_way;
  bit        m_inv;

  function automatic bit [15:0] lfsr_next(input bit [15:0] s);
    bit [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    bit [15:0] nv;
    int        low;
    if (reset) begin
      m_valid <= 16'h0;
      m_lfsr  <= 16'hACE1;
      m_offer <= 1'b0;
      m_way   <= 0;
      m_inv   <= 1'b0;
    end else begin
      nv = m_valid;
      if (fill_en) nv[fill_way] = 1'b1;
      for (int p = 0; p < NUM_INV; p++)
        if (inv_en[p]) nv[inv_way[p*WAY_W +: WAY_W]] = 1'b0;
      m_valid <= nv;
      m_lfsr  <= lfsr_next(m_lfsr);
      if (!m_offer && victim_req) begin
        low = -1;
        for (int i = WAYS - 1; i >= 0; i--)
          if (!m_valid[i]) low = i;
        m_offer <= 1'b1;
        m_inv   <= (low >= 0);
        m_way   <= (low >= 0) ? low : int'(m_lfsr[3:0]);
      end else if (m_offer && victim_ready) begin
        m_offer <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("victim_valid", 64'(victim_valid), 64'(m_offer));
      chk("victim_way", 64'(victim_way), 64'(m_way));
      chk("victim_invalid", 64'(victim_invalid), 64'(m_inv));
      chk("valid_out", 64'(valid_out), 64'(m_valid));
      chk("valid_count", 64'(valid_count), 64'($countones(m_valid)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    inv_en = '0; inv_way = '0; fill_en = 1'b0; fill_way = '0;
    victim_req = 1'b0; victim_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_way;
    reset = 1'b1;
    idle_inputs();
    tick();
    started = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_valid_out", 64'(valid_out), 64'h0);
    chk("reset_victim_valid", 64'(victim_valid), 64'h0);

    // Request straight after reset: lowest invalid is way 0
    victim_req = 1'b1;
    tick();
    victim_req = 1'b0;
    @(negedge clk);
    chk("t1_vv", 64'(victim_valid), 64'h1);
    chk("t1_way", 64'(victim_way), 64'h0);
    chk("t1_inv", 64'(victim_invalid), 64'h1);
    victim_ready = 1'b1;
    tick();
    victim_ready = 1'b0;
    @(negedge clk);
    chk("t1_drop", 64'(victim_valid), 64'h0);

    // Fill every way, then request a random victim
    for (int w = 0; w < WAYS; w++) begin
      fill_en = 1'b1; fill_way = 4'(w);
      tick();
    end
    fill_en = 1'b0;
    tick();
    @(negedge clk);
    chk("t2_count", 64'(valid_count), 64'd16);
    victim_req = 1'b1;
    exp_way = m_lfsr[3:0];
    tick();
    victim_req = 1'b0;
    @(negedge clk);
    chk("t2_inv", 64'(victim_invalid), 64'h0);
    chk("t2_way", 64'(victim_way), 64'(exp_way));
    victim_ready = 1'b1;
    tick();
    victim_ready = 1'b0;

    // Two invalidates in one cycle
    inv_en = 2'b11; inv_way = {4'd9, 4'd3};
    tick();
    inv_en = '0;
    @(negedge clk);
    chk("t3_valid", 64'(valid_out), 64'hFDF7);
    chk("t3_count", 64'(valid_count), 64'd14);
    victim_req = 1'b1;
    tick();
    victim_req = 1'b0;
    @(negedge clk);
    chk("t3_way", 64'(victim_way), 64'd3);
    victim_ready = 1'b1;
    tick();
    victim_ready = 1'b0;

    // Invalidate beats fill on the same way
    fill_en = 1'b1; fill_way = 4'd5; inv_en = 2'b01; inv_way = {4'd0, 4'd5};
    tick();
    fill_en = 1'b0; inv_en = '0;
    @(negedge clk);
    chk("t4_bit5", 64'(valid_out[5]), 64'h0);

    // Make way 2 the only invalid way, then hold the offer while it gets filled
    fill_en = 1'b1; fill_way = 4'd3; inv_en = 2'b01; inv_way = {4'd0, 4'd2};
    tick();
    inv_en = '0; fill_way = 4'd5;
    tick();
    fill_way = 4'd9;
    tick();
    fill_en = 1'b0;
    victim_req = 1'b1;
    tick();
    victim_req = 1'b0;
    fill_en = 1'b1; fill_way = 4'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_way", 64'(victim_way), 64'd2);
      chk("t5_inv", 64'(victim_invalid), 64'h1);
      chk("t5_vv", 64'(victim_valid), 64'h1);
      tick();
      fill_en = 1'b0;
    end
    victim_ready = 1'b1;
    tick();
    victim_ready = 1'b0;
    @(negedge clk);
    chk("t5_accept", 64'(victim_valid), 64'h0);

    // Reset in the middle of an offer
    victim_req = 1'b1;
    tick();
    victim_req = 1'b0;
    @(negedge clk);
    chk("t6_pre_vv", 64'(victim_valid), 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_vv", 64'(victim_valid), 64'h0);
    chk("t6_valid", 64'(valid_out), 64'h0);
    chk("t6_model_lfsr", 64'(m_lfsr), 64'hACE1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 299) == 0);
      inv_en       = NUM_INV'($urandom_range(0, 3)) & {NUM_INV{($urandom_range(0, 2) == 0)}};
      inv_way      = (NUM_INV*WAY_W)'($urandom);
      fill_en      = ($urandom_range(0, 1) == 1);
      fill_way     = WAY_W'($urandom);
      victim_req   = ($urandom_range(0, 2) == 0);
      victim_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    idle_inputs();
    reset = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
